// File: rtl/avalon_burst_arbiter.sv
// Two-requester round-robin arbiter sharing one Avalon-MM burst port.
// The grant is held until the last read beat returns or the last write beat is accepted.
module avalon_burst_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 5
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [ADDR_W-1:0]  r0_address,
   input  logic               r0_read,
   input  logic               r0_write,
   input  logic [DATA_W-1:0]  r0_writedata,
   input  logic [BURST_W-1:0] r0_burstcount,
   output logic               r0_waitrequest,
   output logic [DATA_W-1:0]  r0_readdata,
   output logic               r0_readdatavalid,
   input  logic [ADDR_W-1:0]  r1_address,
   input  logic               r1_read,
   input  logic               r1_write,
   input  logic [DATA_W-1:0]  r1_writedata,
   input  logic [BURST_W-1:0] r1_burstcount,
   output logic               r1_waitrequest,
   output logic [DATA_W-1:0]  r1_readdata,
   output logic               r1_readdatavalid,
   output logic [ADDR_W-1:0]  av_address,
   output logic               av_read,
   output logic               av_write,
   output logic [DATA_W-1:0]  av_writedata,
   output logic [BURST_W-1:0] av_burstcount,
   output logic               av_beginbursttransfer,
   input  logic               av_waitrequest,
   input  logic [DATA_W-1:0]  av_readdata,
   input  logic               av_readdatavalid
);

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      RD_DATA,
      WR
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic               grant;
   logic               grant_nx;
   logic [BURST_W-1:0] cnt;
   logic [BURST_W-1:0] cnt_nx;
   logic               first;
   logic               first_nx;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  addr_nx;
   logic [BURST_W-1:0] bc_q;
   logic [BURST_W-1:0] bc_nx;

   logic               req0;
   logic               req1;
   logic               win;
   logic               w_read;
   logic [ADDR_W-1:0]  w_address;
   logic [BURST_W-1:0] w_burstcount;

   logic               g_read;
   logic               g_write;
   logic [ADDR_W-1:0]  g_address;
   logic [DATA_W-1:0]  g_writedata;
   logic [BURST_W-1:0] g_burstcount;

   assign req0 = r0_read | r0_write;
   assign req1 = r1_read | r1_write;

   // grant holds the last winner, so on a tie the other side goes next
   assign win = (req0 & req1) ? ~grant : req1;

   assign w_read       = win ? r1_read       : r0_read;
   assign w_address    = win ? r1_address    : r0_address;
   assign w_burstcount = win ? r1_burstcount : r0_burstcount;

   assign g_read       = grant ? r1_read       : r0_read;
   assign g_write      = grant ? r1_write      : r0_write;
   assign g_address    = grant ? r1_address    : r0_address;
   assign g_writedata  = grant ? r1_writedata  : r0_writedata;
   assign g_burstcount = grant ? r1_burstcount : r0_burstcount;

   assign r0_readdata = av_readdata;
   assign r1_readdata = av_readdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         grant  <= 1'b1;
         cnt    <= '0;
         first  <= 1'b0;
         addr_q <= '0;
         bc_q   <= '0;
      end else begin
         state  <= state_nx;
         grant  <= grant_nx;
         cnt    <= cnt_nx;
         first  <= first_nx;
         addr_q <= addr_nx;
         bc_q   <= bc_nx;
      end
   end

   always_comb begin
      state_nx              = state;
      grant_nx              = grant;
      cnt_nx                = cnt;
      first_nx              = 1'b0;
      addr_nx               = addr_q;
      bc_nx                 = bc_q;
      av_address            = '0;
      av_read               = 1'b0;
      av_write              = 1'b0;
      av_writedata          = '0;
      av_burstcount         = '0;
      av_beginbursttransfer = 1'b0;
      r0_waitrequest        = 1'b1;
      r1_waitrequest        = 1'b1;
      r0_readdatavalid      = 1'b0;
      r1_readdatavalid      = 1'b0;

      unique case (state)
         IDLE: begin
            if (req0 | req1) begin
               grant_nx = win;
               addr_nx  = w_address;
               bc_nx    = w_burstcount;
               first_nx = 1'b1;
               // a zero burstcount still moves one beat
               if (w_burstcount == '0) begin
                  cnt_nx = BURST_W'(1);
               end else begin
                  cnt_nx = w_burstcount;
               end
               state_nx = w_read ? RD_CMD : WR;
            end
         end

         RD_CMD: begin
            av_read               = g_read;
            av_address            = g_address;
            av_burstcount         = g_burstcount;
            av_writedata          = g_writedata;
            av_beginbursttransfer = first;
            if (grant) begin
               r1_waitrequest = av_waitrequest;
            end else begin
               r0_waitrequest = av_waitrequest;
            end
            if (g_read && !av_waitrequest) begin
               state_nx = RD_DATA;
            end
         end

         RD_DATA: begin
            if (grant) begin
               r1_readdatavalid = av_readdatavalid;
            end else begin
               r0_readdatavalid = av_readdatavalid;
            end
            if (av_readdatavalid) begin
               cnt_nx = cnt - 1'b1;
               if (cnt == BURST_W'(1)) begin
                  state_nx = IDLE;
               end
            end
         end

         WR: begin
            // address and length stay as captured at the first beat
            av_write              = g_write;
            av_writedata          = g_writedata;
            av_address            = addr_q;
            av_burstcount         = bc_q;
            av_beginbursttransfer = first;
            if (grant) begin
               r1_waitrequest = av_waitrequest;
            end else begin
               r0_waitrequest = av_waitrequest;
            end
            if (g_write && !av_waitrequest) begin
               cnt_nx = cnt - 1'b1;
               if (cnt == BURST_W'(1)) begin
                  state_nx = IDLE;
               end
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// Directed bench for avalon_burst_arbiter: reads, round-robin, gapped writes,
// zero-length bursts, mid-burst reset and stray read data.
module tb_avalon_burst_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] r0_address;
   logic        r0_read;
   logic        r0_write;
   logic [31:0] r0_writedata;
   logic [4:0]  r0_burstcount;
   logic        r0_waitrequest;
   logic [31:0] r0_readdata;
   logic        r0_readdatavalid;
   logic [31:0] r1_address;
   logic        r1_read;
   logic        r1_write;
   logic [31:0] r1_writedata;
   logic [4:0]  r1_burstcount;
   logic        r1_waitrequest;
   logic [31:0] r1_readdata;
   logic        r1_readdatavalid;
   logic [31:0] av_address;
   logic        av_read;
   logic        av_write;
   logic [31:0] av_writedata;
   logic [4:0]  av_burstcount;
   logic        av_beginbursttransfer;
   logic        av_waitrequest;
   logic [31:0] av_readdata;
   logic        av_readdatavalid;

   int          n_assert;
   int          n_fail;
   int          n0;
   logic [31:0] wq[$];

   always #5 clk = ~clk;

   avalon_burst_arbiter #(
      .ADDR_W (32),
      .DATA_W (32),
      .BURST_W(5)
   ) dut (
      .clk                  (clk),
      .resetn               (resetn),
      .r0_address           (r0_address),
      .r0_read              (r0_read),
      .r0_write             (r0_write),
      .r0_writedata         (r0_writedata),
      .r0_burstcount        (r0_burstcount),
      .r0_waitrequest       (r0_waitrequest),
      .r0_readdata          (r0_readdata),
      .r0_readdatavalid     (r0_readdatavalid),
      .r1_address           (r1_address),
      .r1_read              (r1_read),
      .r1_write             (r1_write),
      .r1_writedata         (r1_writedata),
      .r1_burstcount        (r1_burstcount),
      .r1_waitrequest       (r1_waitrequest),
      .r1_readdata          (r1_readdata),
      .r1_readdatavalid     (r1_readdatavalid),
      .av_address           (av_address),
      .av_read              (av_read),
      .av_write             (av_write),
      .av_writedata         (av_writedata),
      .av_burstcount        (av_burstcount),
      .av_beginbursttransfer(av_beginbursttransfer),
      .av_waitrequest       (av_waitrequest),
      .av_readdata          (av_readdata),
      .av_readdatavalid     (av_readdatavalid)
   );

   always @(posedge clk) begin
      if (resetn && av_write && !av_waitrequest) begin
         wq.push_back(av_writedata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in the first RD_CMD window with av_waitrequest already low;
   // leaves in the IDLE window after the last beat.
   task automatic serve_read(input int k, input logic [31:0] addr,
                             input int beats, input logic exp_begin);
      logic [31:0] d;
      #1;
      chk("rd_begin", 32'(av_beginbursttransfer), 32'(exp_begin));
      chk("rd_av_read", 32'(av_read), 32'd1);
      chk("rd_addr", av_address, addr);
      chk("rd_wait_granted",
          32'((k == 1) ? r1_waitrequest : r0_waitrequest), 32'd0);
      chk("rd_wait_other",
          32'((k == 1) ? r0_waitrequest : r1_waitrequest), 32'd1);
      tick();
      if (k == 1) r1_read = 1'b0;
      else        r0_read = 1'b0;
      for (int i = 0; i < beats; i++) begin
         d = 32'hD000_0000 + 32'(k * 256 + i);
         av_readdatavalid = 1'b1;
         av_readdata      = d;
         #1;
         chk("rd_beat_valid",
             32'((k == 1) ? r1_readdatavalid : r0_readdatavalid), 32'd1);
         chk("rd_beat_other",
             32'((k == 1) ? r0_readdatavalid : r1_readdatavalid), 32'd0);
         chk("rd_beat_data", (k == 1) ? r1_readdata : r0_readdata, d);
         tick();
      end
      av_readdatavalid = 1'b0;
   endtask

   initial begin
      n_assert         = 0;
      n_fail           = 0;
      resetn           = 1'b0;
      r0_address       = '0;
      r0_read          = 1'b0;
      r0_write         = 1'b0;
      r0_writedata     = '0;
      r0_burstcount    = '0;
      r1_address       = '0;
      r1_read          = 1'b0;
      r1_write         = 1'b0;
      r1_writedata     = '0;
      r1_burstcount    = '0;
      av_waitrequest   = 1'b0;
      av_readdata      = '0;
      av_readdatavalid = 1'b0;

      #2;
      chk("rst_av_read", 32'(av_read), 32'd0);
      chk("rst_av_write", 32'(av_write), 32'd0);
      chk("rst_begin", 32'(av_beginbursttransfer), 32'd0);
      chk("rst_addr", av_address, 32'd0);
      chk("rst_wdata", av_writedata, 32'd0);
      chk("rst_bc", 32'(av_burstcount), 32'd0);
      chk("rst_r0_wait", 32'(r0_waitrequest), 32'd1);
      chk("rst_r1_wait", 32'(r1_waitrequest), 32'd1);
      chk("rst_r0_rdv", 32'(r0_readdatavalid), 32'd0);
      chk("rst_r1_rdv", 32'(r1_readdatavalid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // instruction read, burst 8, two stall cycles
      r0_address     = 32'h0000_1000;
      r0_burstcount  = 5'd8;
      r0_read        = 1'b1;
      av_waitrequest = 1'b1;
      #1;
      chk("t1_idle_wait", 32'(r0_waitrequest), 32'd1);
      chk("t1_idle_rd", 32'(av_read), 32'd0);
      tick();
      #1;
      chk("t1_begin", 32'(av_beginbursttransfer), 32'd1);
      chk("t1_av_read", 32'(av_read), 32'd1);
      chk("t1_addr", av_address, 32'h0000_1000);
      chk("t1_bc", 32'(av_burstcount), 32'd8);
      chk("t1_stall_wait", 32'(r0_waitrequest), 32'd1);
      tick();
      #1;
      chk("t1_begin_once", 32'(av_beginbursttransfer), 32'd0);
      chk("t1_r1_wait", 32'(r1_waitrequest), 32'd1);
      tick();
      av_waitrequest = 1'b0;
      serve_read(0, 32'h0000_1000, 8, 1'b0);
      av_readdatavalid = 1'b1;
      #1;
      chk("t1_stray_r0", 32'(r0_readdatavalid), 32'd0);
      chk("t1_stray_r1", 32'(r1_readdatavalid), 32'd0);
      av_readdatavalid = 1'b0;

      // simultaneous reads after reset alternate 0,1,0,1
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      r0_address    = 32'h0000_2000;
      r0_burstcount = 5'd2;
      r0_read       = 1'b1;
      r1_address    = 32'h0000_3000;
      r1_burstcount = 5'd2;
      r1_read       = 1'b1;
      tick();
      serve_read(0, 32'h0000_2000, 2, 1'b1);
      #1;
      chk("t2_idle_r1_wait", 32'(r1_waitrequest), 32'd1);
      tick();
      serve_read(1, 32'h0000_3000, 2, 1'b1);
      r0_read = 1'b1;
      r1_read = 1'b1;
      tick();
      serve_read(0, 32'h0000_2000, 2, 1'b1);
      tick();
      serve_read(1, 32'h0000_3000, 2, 1'b1);

      // data write burst 4 with gaps and stalls, r0 read held off
      n0            = wq.size();
      r1_address    = 32'h0000_4000;
      r1_burstcount = 5'd4;
      r1_writedata  = 32'hA000_0000;
      r1_write      = 1'b1;
      #1;
      chk("t3_idle_wait", 32'(r1_waitrequest), 32'd1);
      tick();
      r0_address     = 32'h0000_5000;
      r0_burstcount  = 5'd1;
      r0_read        = 1'b1;
      av_waitrequest = 1'b1;
      #1;
      chk("t3_begin", 32'(av_beginbursttransfer), 32'd1);
      chk("t3_av_write", 32'(av_write), 32'd1);
      chk("t3_addr", av_address, 32'h0000_4000);
      chk("t3_bc", 32'(av_burstcount), 32'd4);
      chk("t3_r1_stall", 32'(r1_waitrequest), 32'd1);
      chk("t3_r0_wait", 32'(r0_waitrequest), 32'd1);
      tick();
      av_waitrequest = 1'b0;
      r1_address     = 32'h0000_0BAD;
      r1_burstcount  = 5'd7;
      #1;
      chk("t3_r1_go", 32'(r1_waitrequest), 32'd0);
      chk("t3_begin_once", 32'(av_beginbursttransfer), 32'd0);
      chk("t3_addr_held", av_address, 32'h0000_4000);
      chk("t3_bc_held", 32'(av_burstcount), 32'd4);
      tick();
      r1_write = 1'b0;
      #1;
      chk("t3_gap", 32'(av_write), 32'd0);
      chk("t3_gap_r0_wait", 32'(r0_waitrequest), 32'd1);
      tick();
      r1_write     = 1'b1;
      r1_writedata = 32'hA000_0001;
      tick();
      r1_writedata   = 32'hA000_0002;
      av_waitrequest = 1'b1;
      #1;
      chk("t3_stall2", 32'(r1_waitrequest), 32'd1);
      tick();
      av_waitrequest = 1'b0;
      tick();
      r1_writedata = 32'hA000_0003;
      #1;
      chk("t3_wdata3", av_writedata, 32'hA000_0003);
      chk("t3_last_r0_wait", 32'(r0_waitrequest), 32'd1);
      tick();
      r1_write = 1'b0;
      #1;
      chk("t3_beats", 32'(wq.size() - n0), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (n0 + i < wq.size()) begin
            chk("t3_wdata_order", wq[n0 + i], 32'hA000_0000 + 32'(i));
         end
      end
      chk("t3_idle_r0_wait", 32'(r0_waitrequest), 32'd1);
      chk("t3_idle_write", 32'(av_write), 32'd0);
      tick();
      serve_read(0, 32'h0000_5000, 1, 1'b1);

      // burstcount 0 moves exactly one beat
      r0_address    = 32'h0000_6000;
      r0_burstcount = 5'd0;
      r0_read       = 1'b1;
      tick();
      serve_read(0, 32'h0000_6000, 1, 1'b1);
      av_readdatavalid = 1'b1;
      #1;
      chk("t4_idle_after_one", 32'(r0_readdatavalid), 32'd0);
      av_readdatavalid = 1'b0;

      // reset during beat 3 of 8
      r0_address    = 32'h0000_7000;
      r0_burstcount = 5'd8;
      r0_read       = 1'b1;
      tick();
      #1;
      chk("t5_cmd_wait", 32'(r0_waitrequest), 32'd0);
      tick();
      r0_read          = 1'b0;
      av_readdatavalid = 1'b1;
      tick();
      tick();
      #1;
      chk("t5_beat3", 32'(r0_readdatavalid), 32'd1);
      resetn = 1'b0;
      #1;
      chk("t5_rst_rdv", 32'(r0_readdatavalid), 32'd0);
      chk("t5_rst_r0_wait", 32'(r0_waitrequest), 32'd1);
      chk("t5_rst_r1_wait", 32'(r1_waitrequest), 32'd1);
      chk("t5_rst_av_read", 32'(av_read), 32'd0);
      chk("t5_rst_addr", av_address, 32'd0);
      @(negedge clk);
      resetn           = 1'b1;
      av_readdatavalid = 1'b0;
      tick();
      r1_address    = 32'h0000_8000;
      r1_burstcount = 5'd1;
      r1_read       = 1'b1;
      tick();
      serve_read(1, 32'h0000_8000, 1, 1'b1);
      #1;
      chk("t5_end_idle", 32'(av_read), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
